keypad_reader: RTL

Input-side counterpart of the 4-digit seven-segment display path: scans a 4x4 matrix keypad, debounces it, and assembles entered hex digits into a 16-bit value. The display path shows four hex digits; this block lets the user type them. It sits in the top level beside the counter/display logic, and its `dat` output feeds the same 16-bit display/LED data path.

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/keypad_reader_scan_tick.sv | 33 +++
 rtl/keypad_reader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad reader.
//   state_t     : scan / debounce / held states of the keypad FSM
//   KEY_W       : width of a key code {row_idx, col_idx}
//   N_LINES     : number of keypad rows and of keypad columns
//   DAT_W       : width of the assembled entry value
//   col_drive() : active-low one-cold column drive pattern for a column index
//   low_row_idx(): index of the lowest-numbered low (pressed) row
package keypad_pkg;

   localparam int unsigned KEY_W   = 4;
   localparam int unsigned N_LINES = 4;
   localparam int unsigned DAT_W   = 16;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HELD
   } state_t;

   function automatic logic [N_LINES-1:0] col_drive(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

   // Lowest index wins when several rows are pulled low together.
   function automatic logic [1:0] low_row_idx(input logic [N_LINES-1:0] rows);
      logic [1:0] idx;
      logic       found;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N_LINES; i++) begin
         if (!rows[i] && !found) begin
            idx   = 2'(i);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_reader_scan_tick.sv
// scan_tick: free-running divider producing a one-cycle tick every
// CLKFREQ/SCAN_HZ clock cycles (CLKFREQ/SCAN_HZ must be >= 2).
//   i_clk  : system clock, rising edge
//   i_rst  : asynchronous active-high reset, counter restarts at 0
//   o_tick : high for the single cycle in which the count is TICK_DIV-1
module scan_tick #(
   parameter int unsigned CLKFREQ = 27_000_000,
   parameter int unsigned SCAN_HZ = 1000
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_tick
);

   localparam int unsigned TICK_DIV = CLKFREQ / SCAN_HZ;
   localparam int unsigned TW       = $clog2(TICK_DIV);
   localparam logic [TW-1:0] LAST   = TW'(TICK_DIV - 1);

   logic [TW-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + TW'(1);
      end
   end

   assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/keypad_reader.sv
// keypad_reader: scans a 4x4 active-low matrix keypad one column per scan
// tick, debounces press and release, and shifts each accepted hex key code
// into a 16-bit entry value.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   row       : keypad rows, active-low, asynchronous to clk
//   col       : keypad column drive, active-low, exactly one bit low
//   clr       : synchronous clear of dat (has priority over a new key)
//   key_valid : one-cycle pulse per accepted key
//   key_code  : last accepted key, {row_idx, col_idx}
//   dat       : entered value, newest digit in the low nibble
module keypad_reader
   import keypad_pkg::*;
#(
   parameter int unsigned CLKFREQ     = 27_000_000,
   parameter int unsigned SCAN_HZ     = 1000,
   parameter int unsigned DEBOUNCE_MS = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_LINES-1:0] row,
   output logic [N_LINES-1:0] col,
   input  logic               clr,
   output logic               key_valid,
   output logic [KEY_W-1:0]   key_code,
   output logic [DAT_W-1:0]   dat
);

   localparam int unsigned DB_TICKS = DEBOUNCE_MS * SCAN_HZ / 1000;
   // One spare count so db_cnt+1 never wraps before the compare.
   localparam int unsigned CW       = $clog2(DB_TICKS + 2);
   localparam logic [CW-1:0] DB_MAX = CW'(DB_TICKS);

   logic               w_tick;
   logic [N_LINES-1:0] r_row_meta;
   logic [N_LINES-1:0] r_row_s;
   state_t             r_state;
   logic [1:0]         r_col_idx;
   logic [1:0]         r_row_idx;
   logic [N_LINES-1:0] r_col;
   logic [CW-1:0]      r_db_cnt;
   logic               r_key_valid;
   logic [KEY_W-1:0]   r_key_code;
   logic [DAT_W-1:0]   r_dat;

   logic [CW-1:0]      w_db_next;
   logic               w_db_done;
   logic               w_row_low;
   logic [1:0]         w_col_next;
   logic [KEY_W-1:0]   w_code;

   scan_tick #(
      .CLKFREQ(CLKFREQ),
      .SCAN_HZ(SCAN_HZ)
   ) u_scan_tick (
      .i_clk (clk),
      .i_rst (rst),
      .o_tick(w_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row_meta <= '1;
         r_row_s    <= '1;
      end else begin
         r_row_meta <= row;
         r_row_s    <= r_row_meta;
      end
   end

   assign w_db_next  = r_db_cnt + CW'(1);
   assign w_db_done  = (w_db_next >= DB_MAX);
   assign w_row_low  = ~r_row_s[r_row_idx];
   assign w_col_next = r_col_idx + 2'd1;
   assign w_code     = {r_row_idx, r_col_idx};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_SCAN;
         r_col_idx   <= '0;
         r_row_idx   <= '0;
         r_col       <= col_drive(2'd0);
         r_db_cnt    <= '0;
         r_key_valid <= 1'b0;
         r_key_code  <= '0;
         r_dat       <= '0;
      end else begin
         r_key_valid <= 1'b0;
         if (w_tick) begin
            case (r_state)
               ST_SCAN: begin
                  if (r_row_s != '1) begin
                     // Column stays driven so the same key can be tracked.
                     r_row_idx <= low_row_idx(r_row_s);
                     r_db_cnt  <= CW'(1);
                     r_state   <= ST_DEBOUNCE;
                  end else begin
                     r_col_idx <= w_col_next;
                     r_col     <= col_drive(w_col_next);
                  end
               end
               ST_DEBOUNCE: begin
                  if (w_row_low) begin
                     if (w_db_done) begin
                        r_key_valid <= 1'b1;
                        r_key_code  <= w_code;
                        r_dat       <= {r_dat[DAT_W-KEY_W-1:0], w_code};
                        r_db_cnt    <= '0;
                        r_state     <= ST_HELD;
                     end else begin
                        r_db_cnt <= w_db_next;
                     end
                  end else begin
                     r_db_cnt  <= '0;
                     r_state   <= ST_SCAN;
                     r_col_idx <= w_col_next;
                     r_col     <= col_drive(w_col_next);
                  end
               end
               ST_HELD: begin
                  // Release must be seen on consecutive ticks; any low restarts it.
                  if (!w_row_low) begin
                     if (w_db_done) begin
                        r_db_cnt  <= '0;
                        r_state   <= ST_SCAN;
                        r_col_idx <= w_col_next;
                        r_col     <= col_drive(w_col_next);
                     end else begin
                        r_db_cnt <= w_db_next;
                     end
                  end else begin
                     r_db_cnt <= '0;
                  end
               end
               default: r_state <= ST_SCAN;
            endcase
         end
         // Later assignment overrides a same-cycle key shift.
         if (clr) begin
            r_dat <= '0;
         end
      end
   end

   assign col       = r_col;
   assign key_valid = r_key_valid;
   assign key_code  = r_key_code;
   assign dat       = r_dat;

endmodule
